// File: rtl/lab72_soc_usb_gpx_event_ctrl.sv
//------------------------------------------------------------------------------
// Module   : lab72_soc_usb_gpx_event_ctrl
// Brief    : Avalon-MM GPX pin event controller (sync, deglitch, edge capture,
//            saturating event counter, maskable level IRQ).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lab72_soc_usb_gpx_event_ctrl #(
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        in_port,
    output logic        irq
);

    localparam logic [7:0]       FC_LAST = 8'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sync1_q, sync2_q;
    logic             filt_q, filt_d;
    logic             filt_dly_q;
    logic [7:0]       fc_q, fc_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             status_q, status_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             irq_q;
    logic [31:0]      rdata_q, rdata_d;

    logic             rise, fall, evt, wr;
    logic             w_unused;

    assign w_unused = &{1'b0, writedata[31:3], 1'b0};

    // A level change is accepted only after FILTER_CYCLES consecutive mismatches.
    always_comb begin
        fc_d   = fc_q;
        filt_d = filt_q;
        if (sync2_q == filt_q) begin
            fc_d = 8'd0;
        end else if (fc_q == FC_LAST) begin
            filt_d = sync2_q;
            fc_d   = 8'd0;
        end else begin
            fc_d = 8'(fc_q + 8'd1);
        end
    end

    assign rise = filt_q & ~filt_dly_q;
    assign fall = ~filt_q & filt_dly_q;
    assign evt  = (rise & ctrl_q[1]) | (fall & ctrl_q[2]);
    assign wr   = chipselect & ~write_n;

    always_comb begin
        ctrl_d   = ctrl_q;
        status_d = status_q;
        count_d  = count_q;
        if (wr && address == 2'd1) begin
            ctrl_d = writedata[2:0];
        end
        // A new event takes priority over a software clear.
        if (evt) begin
            status_d = 1'b1;
        end else if (wr && address == 2'd2 && writedata[0]) begin
            status_d = 1'b0;
        end
        if (wr && address == 2'd3) begin
            count_d = evt ? CNT_W'(1) : '0;
        end else if (evt && count_q != CNT_MAX) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_comb begin
        rdata_d = 32'd0;
        case (address)
            2'd0:    rdata_d = {31'd0, filt_q};
            2'd1:    rdata_d = {29'd0, ctrl_q};
            2'd2:    rdata_d = {31'd0, status_q};
            default: rdata_d = 32'(count_q);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
            fc_q       <= 8'd0;
            ctrl_q     <= 3'd0;
            status_q   <= 1'b0;
            count_q    <= '0;
            irq_q      <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            fc_q       <= fc_d;
            ctrl_q     <= ctrl_d;
            status_q   <= status_d;
            count_q    <= count_d;
            irq_q      <= status_q & ctrl_q[0];
            rdata_q    <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;

endmodule

`default_nettype wire
